op4_arbiter: RTL and testbench

Sequencing and sharing front end for the single-cycle signed 8-bit multiplier (`op4`) in the scalar pipeline. It arbitrates two requesters onto one multiplier instance using round-robin, with fixed priority as an option. It registers operands for one issue stage and returns each product through a per-port one-entry response buffer with valid/ready backpressure. Requester A is the execute-stage MUL path and requester B is the auxiliary/address-scaling path. Neither requester needs to know about the other.

---
 rtl/op4_arbiter.sv | 175 +++++++++++++++++
 tb/tb_op4_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/op4_arbiter.sv
// Two-port front end for the shared op4 signed 8x8 multiplier: arbitration,
// one issue stage, and a one-entry response buffer per requester.
`timescale 1ns/1ps
module op4_arbiter #(
   parameter logic RR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        a_valid,
   output logic        a_ready,
   input  logic [11:0] a_op1,
   input  logic [11:0] a_op2,
   output logic        a_res_valid,
   input  logic        a_res_ready,
   output logic [11:0] a_result,

   input  logic        b_valid,
   output logic        b_ready,
   input  logic [11:0] b_op1,
   input  logic [11:0] b_op2,
   output logic        b_res_valid,
   input  logic        b_res_ready,
   output logic [11:0] b_result,

   output logic        busy
);

   localparam int DATA_W = 8;
   localparam int RES_W  = 12;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   function automatic logic [RES_W-1:0] trunc_prod(
      input logic signed [DATA_W-1:0] x,
      input logic signed [DATA_W-1:0] y
   );
      logic signed [2*DATA_W-1:0] p;
      p = (2*DATA_W)'(x) * (2*DATA_W)'(y);
      return {{(RES_W-DATA_W){1'b0}}, p[DATA_W-1:0]};
   endfunction

   // Control state
   logic  out_a_q, out_a_d;
   logic  out_b_q, out_b_d;
   port_e last_q, last_d;

   // Issue stage S1
   logic                     vld_p1_q, vld_p1_d;
   port_e                    tag_p1_q, tag_p1_d;
   logic signed [DATA_W-1:0] op1_p1_q, op1_p1_d;
   logic signed [DATA_W-1:0] op2_p1_q, op2_p1_d;

   // Response buffers
   logic             a_res_valid_q, a_res_valid_d;
   logic             b_res_valid_q, b_res_valid_d;
   logic [RES_W-1:0] a_result_q, a_result_d;
   logic [RES_W-1:0] b_result_q, b_result_d;

   logic             a_hs, b_hs;
   logic             elig_a, elig_b;
   logic             cand_a, cand_b;
   logic             grant_a, grant_b;
   logic             acc_a, acc_b;
   logic [RES_W-1:0] prod_p1;

   // Upper operand bits are architecturally ignored.
   logic unused_op_hi;
   assign unused_op_hi = ^{a_op1[11:8], a_op2[11:8], b_op1[11:8], b_op2[11:8]};

   always_comb begin
      a_hs    = a_res_valid_q && a_res_ready;
      b_hs    = b_res_valid_q && b_res_ready;
      // A same-cycle drain frees the slot for a new accept.
      elig_a  = !out_a_q || a_hs;
      elig_b  = !out_b_q || b_hs;
      cand_a  = a_valid && elig_a && !rst;
      cand_b  = b_valid && elig_b && !rst;
      grant_a = cand_a && (!cand_b || !RR || (last_q == PORT_B));
      grant_b = cand_b && !grant_a;
      a_ready = elig_a && grant_a;
      b_ready = elig_b && grant_b;
      acc_a   = a_valid && a_ready;
      acc_b   = b_valid && b_ready;
   end

   always_comb begin
      out_a_d  = out_a_q;
      out_b_d  = out_b_q;
      last_d   = last_q;
      vld_p1_d = acc_a || acc_b;
      tag_p1_d = tag_p1_q;
      op1_p1_d = op1_p1_q;
      op2_p1_d = op2_p1_q;

      if (acc_a) begin
         out_a_d  = 1'b1;
         last_d   = PORT_A;
         tag_p1_d = PORT_A;
         op1_p1_d = a_op1[DATA_W-1:0];
         op2_p1_d = a_op2[DATA_W-1:0];
      end else if (a_hs) begin
         out_a_d  = 1'b0;
      end

      if (acc_b) begin
         out_b_d  = 1'b1;
         last_d   = PORT_B;
         tag_p1_d = PORT_B;
         op1_p1_d = b_op1[DATA_W-1:0];
         op2_p1_d = b_op2[DATA_W-1:0];
      end else if (b_hs) begin
         out_b_d  = 1'b0;
      end
   end

   // ---- S1 -> response buffer: multiplier sits between these registers ----
   assign prod_p1 = trunc_prod(op1_p1_q, op2_p1_q);

   always_comb begin
      a_res_valid_d = a_hs ? 1'b0 : a_res_valid_q;
      b_res_valid_d = b_hs ? 1'b0 : b_res_valid_q;
      a_result_d    = a_result_q;
      b_result_d    = b_result_q;
      if (vld_p1_q) begin
         if (tag_p1_q == PORT_A) begin
            a_res_valid_d = 1'b1;
            a_result_d    = prod_p1;
         end else begin
            b_res_valid_d = 1'b1;
            b_result_d    = prod_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_a_q       <= 1'b0;
         out_b_q       <= 1'b0;
         last_q        <= PORT_B;
         vld_p1_q      <= 1'b0;
         tag_p1_q      <= PORT_A;
         a_res_valid_q <= 1'b0;
         b_res_valid_q <= 1'b0;
         a_result_q    <= '0;
         b_result_q    <= '0;
      end else begin
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         last_q        <= last_d;
         vld_p1_q      <= vld_p1_d;
         tag_p1_q      <= tag_p1_d;
         a_res_valid_q <= a_res_valid_d;
         b_res_valid_q <= b_res_valid_d;
         a_result_q    <= a_result_d;
         b_result_q    <= b_result_d;
      end
   end

   // Operand registers carry data only and need no reset.
   always_ff @(posedge clk) begin
      op1_p1_q <= op1_p1_d;
      op2_p1_q <= op2_p1_d;
   end

   assign a_res_valid = a_res_valid_q;
   assign b_res_valid = b_res_valid_q;
   assign a_result    = a_result_q;
   assign b_result    = b_result_q;
   assign busy        = out_a_q || out_b_q;

endmodule

// File: tb/tb_op4_arbiter.sv
// Directed bench for op4_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream and are checked against hand-computed values.
`timescale 1ns/1ps
module tb_op4_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid, a_res_ready, b_res_ready;
   logic [11:0] a_op1, a_op2, b_op1, b_op2;

   logic        r_a_ready, r_b_ready, r_a_res_valid, r_b_res_valid, r_busy;
   logic [11:0] r_a_result, r_b_result;
   logic        f_a_ready, f_b_ready, f_a_res_valid, f_b_res_valid, f_busy;
   logic [11:0] f_a_result, f_b_result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   op4_arbiter #(.RR(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(r_a_ready), .a_op1(a_op1), .a_op2(a_op2),
      .a_res_valid(r_a_res_valid), .a_res_ready(a_res_ready), .a_result(r_a_result),
      .b_valid(b_valid), .b_ready(r_b_ready), .b_op1(b_op1), .b_op2(b_op2),
      .b_res_valid(r_b_res_valid), .b_res_ready(b_res_ready), .b_result(r_b_result),
      .busy(r_busy)
   );

   op4_arbiter #(.RR(1'b0)) u_fp (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(f_a_ready), .a_op1(a_op1), .a_op2(a_op2),
      .a_res_valid(f_a_res_valid), .a_res_ready(a_res_ready), .a_result(f_a_result),
      .b_valid(b_valid), .b_ready(f_b_ready), .b_op1(b_op1), .b_op2(b_op2),
      .b_res_valid(f_b_res_valid), .b_res_ready(b_res_ready), .b_result(f_b_result),
      .busy(f_busy)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single A op with immediate drain on the round-robin instance.
   task automatic single_a(input string tag, input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] exp);
      a_valid = 1'b1; a_op1 = x; a_op2 = y;
      #1;
      chk({tag, "_ready"}, r_a_ready, 12'd1);
      step();
      a_valid = 1'b0;
      step();
      #1;
      chk({tag, "_resv"}, r_a_res_valid, 12'd1);
      chk({tag, "_res"}, r_a_result, exp);
      step();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1;
      a_res_ready = 1'b1; b_res_ready = 1'b1;
      a_op1 = '0; a_op2 = '0; b_op1 = '0; b_op2 = '0;
      repeat (3) step();
      #1;
      chk("rst_a_ready", r_a_ready, 12'd0);
      chk("rst_b_ready", r_b_ready, 12'd0);
      chk("rst_a_resv", r_a_res_valid, 12'd0);
      chk("rst_b_resv", r_b_res_valid, 12'd0);
      chk("rst_a_res", r_a_result, 12'h000);
      chk("rst_busy", r_busy, 12'd0);
      chk("rst_fp_busy", f_busy, 12'd0);
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      step();

      // Single op on A: 7 x 6
      a_valid = 1'b1; a_op1 = 12'h007; a_op2 = 12'h006;
      #1;
      chk("one_ready", r_a_ready, 12'd1);
      chk("one_busy0", r_busy, 12'd0);
      step();
      a_valid = 1'b0;
      #1;
      chk("one_busy1", r_busy, 12'd1);
      chk("one_resv1", r_a_res_valid, 12'd0);
      step();
      #1;
      chk("one_resv2", r_a_res_valid, 12'd1);
      chk("one_res", r_a_result, 12'h02A);
      chk("one_busy2", r_busy, 12'd1);
      step();
      #1;
      chk("one_resv3", r_a_res_valid, 12'd0);
      chk("one_busy3", r_busy, 12'd0);

      single_a("neg3x5", 12'h0FD, 12'h005, 12'h0F1);
      single_a("100x3", 12'h064, 12'h003, 12'h02C);
      single_a("m128sq", 12'h080, 12'h080, 12'h000);
      single_a("upper", 12'hF07, 12'hA03, 12'h015);

      // last = A on both instances: round-robin favours B, fixed favours A
      a_valid = 1'b1; b_valid = 1'b1;
      a_op1 = 12'h001; a_op2 = 12'h001; b_op1 = 12'h001; b_op2 = 12'h001;
      #1;
      chk("rr_after_a_bready", r_b_ready, 12'd1);
      chk("rr_after_a_aready", r_a_ready, 12'd0);
      chk("fp_after_a_aready", f_a_ready, 12'd1);
      chk("fp_after_a_bready", f_b_ready, 12'd0);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Contention: both requesters hold valid with constant operands
      a_valid = 1'b1; b_valid = 1'b1;
      a_op1 = 12'h002; a_op2 = 12'h003; b_op1 = 12'hFFE; b_op2 = 12'h004;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("cont_rr_aready", r_a_ready, 12'((k % 2) == 0));
         chk("cont_rr_bready", r_b_ready, 12'((k % 2) == 1));
         chk("cont_fp_aready", f_a_ready, 12'((k % 2) == 0));
         chk("cont_fp_bready", f_b_ready, 12'((k % 2) == 1));
         chk("cont_rr_aresv", r_a_res_valid, 12'(k >= 2 && (k % 2) == 0));
         chk("cont_rr_bresv", r_b_res_valid, 12'(k >= 3 && (k % 2) == 1));
         if (k >= 2 && (k % 2) == 0) chk("cont_rr_ares", r_a_result, 12'h006);
         if (k >= 3 && (k % 2) == 1) chk("cont_rr_bres", r_b_result, 12'h0F8);
         step();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (3) step();

      // Backpressure on A's result while B keeps issuing
      a_valid = 1'b1; a_op1 = 12'h005; a_op2 = 12'h005;
      #1;
      chk("bp_a_acc", r_a_ready, 12'd1);
      step();
      a_valid = 1'b0;
      step();
      a_valid = 1'b1; a_op1 = 12'h004; a_op2 = 12'h004;
      a_res_ready = 1'b0;
      b_valid = 1'b1; b_op1 = 12'h003; b_op2 = 12'hFFF;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_a_resv", r_a_res_valid, 12'd1);
         chk("bp_a_res", r_a_result, 12'h019);
         chk("bp_a_ready", r_a_ready, 12'd0);
         chk("bp_b_ready", r_b_ready, 12'((k % 2) == 0));
         if (k == 2 || k == 4) begin
            chk("bp_b_resv", r_b_res_valid, 12'd1);
            chk("bp_b_res", r_b_result, 12'h0FD);
         end
         step();
      end
      a_res_ready = 1'b1; b_valid = 1'b0;
      #1;
      chk("bp_drain_resv", r_a_res_valid, 12'd1);
      chk("bp_reaccept", r_a_ready, 12'd1);
      step();
      a_valid = 1'b0;
      #1;
      chk("bp_a_resv_gap", r_a_res_valid, 12'd0);
      chk("bp_b3_resv", r_b_res_valid, 12'd1);
      chk("bp_b3_res", r_b_result, 12'h0FD);
      step();
      #1;
      chk("bp_a2_resv", r_a_res_valid, 12'd1);
      chk("bp_a2_res", r_a_result, 12'h010);
      step();

      // Reset one cycle after an A accept
      a_valid = 1'b1; a_op1 = 12'h002; a_op2 = 12'h002;
      #1;
      chk("rmid_acc", r_a_ready, 12'd1);
      step();
      a_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rmid_a_resv", r_a_res_valid, 12'd0);
      chk("rmid_b_resv", r_b_res_valid, 12'd0);
      chk("rmid_a_res", r_a_result, 12'h000);
      chk("rmid_b_res", r_b_result, 12'h000);
      chk("rmid_busy", r_busy, 12'd0);
      chk("rmid_a_ready", r_a_ready, 12'd0);
      step();
      #1;
      chk("rmid_no_resp", r_a_res_valid, 12'd0);
      a_valid = 1'b1; a_op1 = 12'h009; a_op2 = 12'h009;
      b_valid = 1'b1; b_op1 = 12'h001; b_op2 = 12'h001;
      #1;
      chk("rmid_a_first", r_a_ready, 12'd1);
      chk("rmid_b_wait", r_b_ready, 12'd0);
      step();
      a_valid = 1'b0;
      #1;
      chk("rmid_b_next", r_b_ready, 12'd1);
      step();
      b_valid = 1'b0;
      #1;
      chk("rmid_a_resv2", r_a_res_valid, 12'd1);
      chk("rmid_a_res2", r_a_result, 12'h051);
      step();
      #1;
      chk("rmid_b_resv2", r_b_res_valid, 12'd1);
      chk("rmid_b_res2", r_b_result, 12'h001);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
